// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter.
//   arb_state_t : arbiter FSM states (IDLE/REQ/WAIT)
//   owner_t     : which requester owns the in-flight transaction
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way pick between fetch and data requesters.
//   req_if, req_d : eligible requests
//   last_owner    : owner of the most recently granted transaction
//   grant_d       : 1 = data wins, 0 = fetch wins (meaningful when valid)
//   valid         : at least one requester is eligible
module arb_pick2
    import mem_arb_pkg::*;
(
    input  logic   req_if,
    input  logic   req_d,
    input  owner_t last_owner,
    output logic   grant_d,
    output logic   valid
);

    assign valid = req_if | req_d;

    // On a tie the requester that did not go last wins.
    assign grant_d = req_d & (~req_if | (last_owner == OWN_IF));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and data requesters.
// One transaction in flight; the winner's request is latched into registered
// memory-side outputs and its response comes back as a one-cycle valid pulse.
//   if_*        : fetch requester (read only)
//   d_*         : data requester (loads and stores)
//   mem_*       : memory request/response channel
//   proto_err_o : sticky, set by a memory response outside WAIT
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    output logic [DATA_W-1:0]     if_rdata_o,
    output logic                  if_valid_o,
    output logic                  if_stall_o,

    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [ADDR_W-1:0]     d_addr_i,
    input  logic [DATA_W-1:0]     d_wdata_i,
    input  logic [DATA_W/8-1:0]   d_be_i,
    output logic [DATA_W-1:0]     d_rdata_o,
    output logic                  d_valid_o,
    output logic                  d_stall_o,

    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    output logic [DATA_W/8-1:0]   mem_be_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_W-1:0]     mem_rdata_i,

    output logic                  proto_err_o
);

    arb_state_t state;
    owner_t     owner;
    owner_t     last_owner;
    logic       pick_valid;
    logic       pick_d;
    logic       elig_if;
    logic       elig_d;

    // A requester whose response is being delivered this cycle is not eligible.
    assign elig_if    = if_req_i & ~if_valid_o;
    assign elig_d     = d_req_i  & ~d_valid_o;
    assign if_stall_o = elig_if;
    assign d_stall_o  = elig_d;

    arb_pick2 u_pick (
        .req_if     (elig_if),
        .req_d      (elig_d),
        .last_owner (last_owner),
        .grant_d    (pick_d),
        .valid      (pick_valid)
    );

    // Arbiter FSM with registered memory-side and response outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            owner       <= OWN_IF;
            last_owner  <= OWN_IF;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_be_o    <= '0;
            if_rdata_o  <= '0;
            if_valid_o  <= 1'b0;
            d_rdata_o   <= '0;
            d_valid_o   <= 1'b0;
            proto_err_o <= 1'b0;
        end else begin
            if_valid_o <= 1'b0;
            d_valid_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_rvalid_i) begin
                        proto_err_o <= 1'b1;
                    end
                    if (pick_valid) begin
                        state     <= REQ;
                        mem_req_o <= 1'b1;
                        if (pick_d) begin
                            owner       <= OWN_D;
                            mem_we_o    <= d_we_i;
                            mem_addr_o  <= d_addr_i;
                            mem_wdata_o <= d_wdata_i;
                            mem_be_o    <= d_be_i;
                        end else begin
                            owner       <= OWN_IF;
                            mem_we_o    <= 1'b0;
                            mem_addr_o  <= if_addr_i;
                            mem_wdata_o <= '0;
                            mem_be_o    <= '1;
                        end
                    end
                end
                REQ: begin
                    // A response in the grant cycle is still too early.
                    if (mem_rvalid_i) begin
                        proto_err_o <= 1'b1;
                    end
                    if (mem_gnt_i) begin
                        state      <= WAIT;
                        mem_req_o  <= 1'b0;
                        last_owner <= owner;
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        state <= IDLE;
                        if (owner == OWN_D) begin
                            d_valid_o <= 1'b1;
                            if (!mem_we_o) begin
                                d_rdata_o <= mem_rdata_i;
                            end
                        end else begin
                            if_valid_o <= 1'b1;
                            if_rdata_o <= mem_rdata_i;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requester sequences push
// expected memory requests and responses; a negedge monitor compares them.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mreq_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_valid_o;
    logic        if_stall_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [3:0]  d_be_i;
    logic [31:0] d_rdata_o;
    logic        d_valid_o;
    logic        d_stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        proto_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    mreq_t       exp_mem[$];
    logic [31:0] exp_if[$];
    logic [31:0] exp_d[$];

    // Memory responder controls.
    logic        resp_en  = 1'b1;
    int          gnt_dly  = 0;
    int          rv_dly   = 0;
    logic        man_gnt  = 1'b0;
    logic        man_rv   = 1'b0;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_rdata_o   (if_rdata_o),
        .if_valid_o   (if_valid_o),
        .if_stall_o   (if_stall_o),
        .d_req_i      (d_req_i),
        .d_we_i       (d_we_i),
        .d_addr_i     (d_addr_i),
        .d_wdata_i    (d_wdata_i),
        .d_be_i       (d_be_i),
        .d_rdata_o    (d_rdata_o),
        .d_valid_o    (d_valid_o),
        .d_stall_o    (d_stall_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .proto_err_o  (proto_err_o)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory model: grants after gnt_dly cycles, responds rv_dly cycles after gnt.
    initial begin
        logic [31:0] a;
        logic        w;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        forever begin
            @(posedge clk_i); #1;
            if (resp_en && mem_req_o) begin
                repeat (gnt_dly) begin @(posedge clk_i); #1; end
                mem_gnt_i = 1'b1;
                a = mem_addr_o;
                w = mem_we_o;
                @(posedge clk_i); #1;
                mem_gnt_i = 1'b0;
                repeat (rv_dly) begin @(posedge clk_i); #1; end
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = w ? 32'hBAD0_BAD0 : mem_word(a);
                @(posedge clk_i); #1;
                mem_rvalid_i = 1'b0;
            end else begin
                mem_gnt_i    = man_gnt;
                mem_rvalid_i = man_rv;
                mem_rdata_i  = 32'h5555_AAAA;
            end
        end
    end

    // Monitor: request fields checked every REQ cycle, popped on grant;
    // response pulses popped against expected read data.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (mem_req_o) begin
                    if (exp_mem.size() == 0) begin
                        chk("unexpected_mem_req", {mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o}, 128'h0);
                    end else begin
                        chk("mem_req_fields", {mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o}, exp_mem[0]);
                        if (mem_gnt_i) void'(exp_mem.pop_front());
                    end
                end
                if (if_valid_o) begin
                    if (exp_if.size() == 0) chk("unexpected_if_valid", 1'b1, 1'b0);
                    else chk("if_rdata", if_rdata_o, exp_if.pop_front());
                end
                if (d_valid_o) begin
                    if (exp_d.size() == 0) chk("unexpected_d_valid", 1'b1, 1'b0);
                    else chk("d_rdata", d_rdata_o, exp_d.pop_front());
                end
            end
        end
    end

    task automatic wait_valid(input bit is_d);
        bit seen = 1'b0;
        for (int k = 0; k < 64 && !seen; k++) begin
            @(negedge clk_i);
            if (is_d ? d_valid_o : if_valid_o) seen = 1'b1;
        end
        if (!seen) chk(is_d ? "d_valid_timeout" : "if_valid_timeout", 1'b0, 1'b1);
    endtask

    task automatic run_if(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            if_addr_i = base + 32'(4 * i);
            if_req_i  = 1'b1;
            wait_valid(1'b0);
            @(posedge clk_i); #1;
        end
        if_req_i = 1'b0;
    endtask

    task automatic run_d(input int n, input logic [31:0] base, input logic we,
                         input logic [3:0] be, input logic [31:0] wd);
        for (int i = 0; i < n; i++) begin
            d_addr_i  = base + 32'(4 * i);
            d_we_i    = we;
            d_be_i    = be;
            d_wdata_i = wd;
            d_req_i   = 1'b1;
            wait_valid(1'b1);
            @(posedge clk_i); #1;
        end
        d_req_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i     = 1'b1;
        if_req_i  = 1'b0;
        if_addr_i = '0;
        d_req_i   = 1'b0;
        d_we_i    = 1'b0;
        d_addr_i  = '0;
        d_wdata_i = '0;
        d_be_i    = '0;

        // Reset state
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_mem_fields", {mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o}, 69'h0);
        chk("rst_valids", {if_valid_o, d_valid_o}, 2'b00);
        chk("rst_rdata", {if_rdata_o, d_rdata_o}, 64'h0);
        chk("rst_proto_err", proto_err_o, 1'b0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Lone fetch with minimum latency
        exp_mem.push_back('{32'h100, 1'b0, 4'hF, 32'h0});
        exp_if.push_back(32'h0050_0093);
        @(posedge clk_i); #1;
        if_addr_i = 32'h100;
        if_req_i  = 1'b1;
        @(negedge clk_i);
        chk("t1_n_stall", if_stall_o, 1'b1);
        chk("t1_n_memreq", mem_req_o, 1'b0);
        @(negedge clk_i);
        chk("t1_n1_memreq", mem_req_o, 1'b1);
        chk("t1_n1_addr", {mem_addr_o, mem_we_o, mem_be_o}, {32'h100, 1'b0, 4'hF});
        chk("t1_n1_stall", if_stall_o, 1'b1);
        @(negedge clk_i);
        chk("t1_n2_memreq", mem_req_o, 1'b0);
        chk("t1_n2_stall_valid", {if_stall_o, if_valid_o}, 2'b10);
        @(negedge clk_i);
        chk("t1_n3_valid", if_valid_o, 1'b1);
        chk("t1_n3_rdata", if_rdata_o, 32'h0050_0093);
        chk("t1_n3_stall", if_stall_o, 1'b0);
        @(posedge clk_i); #1;
        if_req_i = 1'b0;
        repeat (3) @(negedge clk_i);

        // Simultaneous held fetch and load after reset: data first, then strict alternation
        do_reset();
        exp_mem.push_back('{32'h200, 1'b0, 4'hF, 32'h0});
        exp_mem.push_back('{32'h100, 1'b0, 4'hF, 32'h0});
        exp_mem.push_back('{32'h204, 1'b0, 4'hF, 32'h0});
        exp_mem.push_back('{32'h104, 1'b0, 4'hF, 32'h0});
        exp_mem.push_back('{32'h208, 1'b0, 4'hF, 32'h0});
        exp_mem.push_back('{32'h108, 1'b0, 4'hF, 32'h0});
        exp_d.push_back(32'hC0DE_0200);
        exp_d.push_back(32'hC0DE_0204);
        exp_d.push_back(32'hC0DE_0208);
        exp_if.push_back(32'h0050_0093);
        exp_if.push_back(32'hC0DE_0104);
        exp_if.push_back(32'hC0DE_0108);
        @(posedge clk_i); #1;
        fork
            run_if(3, 32'h100);
            run_d(3, 32'h200, 1'b0, 4'hF, 32'h0);
        join
        repeat (3) @(negedge clk_i);
        chk("t2_mem_q_empty", exp_mem.size(), 0);

        // Store with grant and response wait states; load data must be kept
        gnt_dly = 3;
        rv_dly  = 2;
        exp_mem.push_back('{32'h300, 1'b1, 4'b0011, 32'hCAFE_F00D});
        exp_d.push_back(32'hC0DE_0208);
        @(posedge clk_i); #1;
        run_d(1, 32'h300, 1'b1, 4'b0011, 32'hCAFE_F00D);
        repeat (4) @(negedge clk_i);
        chk("t3_d_rdata_hold", d_rdata_o, 32'hC0DE_0208);
        chk("t3_d_q_empty", exp_d.size(), 0);
        gnt_dly = 0;
        rv_dly  = 0;

        // Reset while in WAIT, then a late response
        resp_en = 1'b0;
        exp_mem.push_back('{32'h400, 1'b0, 4'hF, 32'h0});
        @(posedge clk_i); #1;
        d_addr_i  = 32'h400;
        d_we_i    = 1'b0;
        d_be_i    = 4'hF;
        d_wdata_i = '0;
        d_req_i   = 1'b1;
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 16 && !seen; k++) begin
                @(negedge clk_i);
                if (mem_req_o) seen = 1'b1;
            end
            chk("t5_memreq_seen", seen, 1'b1);
        end
        man_gnt = 1'b1;
        @(negedge clk_i);
        man_gnt = 1'b0;
        @(negedge clk_i);
        chk("t5_wait_memreq", mem_req_o, 1'b0);
        chk("t5_proto_before", proto_err_o, 1'b0);
        rst_i   = 1'b1;
        d_req_i = 1'b0;
        @(negedge clk_i);
        chk("t5_rst_outputs", {mem_req_o, mem_we_o, mem_addr_o, mem_be_o, if_valid_o, d_valid_o},
            42'h0);
        chk("t5_rst_rdata", {if_rdata_o, d_rdata_o}, 64'h0);
        chk("t5_rst_proto", proto_err_o, 1'b0);
        rst_i  = 1'b0;
        man_rv = 1'b1;
        @(negedge clk_i);
        man_rv = 1'b0;
        @(negedge clk_i);
        chk("t5_proto_after", proto_err_o, 1'b1);
        chk("t5_no_valid", {d_valid_o, d_rdata_o}, 33'h0);
        resp_en = 1'b1;

        // Response in IDLE is flagged and sticky
        do_reset();
        chk("t6_proto_cleared", proto_err_o, 1'b0);
        resp_en = 1'b0;
        @(negedge clk_i);
        man_rv = 1'b1;
        @(negedge clk_i);
        man_rv = 1'b0;
        @(negedge clk_i);
        chk("t6_proto_set", proto_err_o, 1'b1);
        chk("t6_no_valid", {if_valid_o, d_valid_o, mem_req_o}, 3'b000);
        repeat (5) @(negedge clk_i);
        chk("t6_proto_sticky", proto_err_o, 1'b1);
        do_reset();
        chk("t6_proto_rst", proto_err_o, 1'b0);
        resp_en = 1'b1;

        chk("end_queues_empty", {32'(exp_mem.size()), 32'(exp_if.size()), 32'(exp_d.size())}, 96'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter sharing the core's single-port memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage loads/stores, driven by the decoder's load/store flags). It holds one outstanding transaction and latches the winner's request into registered memory-side outputs. It returns the response to the winner as a one-cycle valid pulse and stalls the losing requester. Arbitration is alternating-priority so neither stage starves.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte enable width is DATA_W/8
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- if_req_i  in  1  fetch request, held until if_valid_o
- if_addr_i  in  ADDR_W  fetch address, stable while if_req_i
- if_rdata_o  out  DATA_W  fetched word, registered
- if_valid_o  out  1  one-cycle response pulse for fetch
- if_stall_o  out  1  if_req_i & ~if_valid_o
- d_req_i  in  1  data request, held until d_valid_o
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  store data
- d_be_i  in  DATA_W/8  byte enables
- d_rdata_o  out  DATA_W  load data, registered
- d_valid_o  out  1  one-cycle response pulse for data
- d_stall_o  out  1  d_req_i & ~d_valid_o
- mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o  out  1/1/ADDR_W/DATA_W/DATA_W/8  registered memory request
- mem_gnt_i  in  1  memory accepts request (mem_req_o & mem_gnt_i)
- mem_rvalid_i  in  1  response, loads and stores
- mem_rdata_i  in  DATA_W  read data, valid with mem_rvalid_i
- proto_err_o  out  1  sticky, mem_rvalid_i seen outside WAIT

## Operation
- States: IDLE, REQ, WAIT. Registers: state, owner (IF/D), last_owner, latched request fields.
- IDLE: eligible requester = req_i high and its valid_o low this cycle. One eligible requester wins. If both are eligible, the one ≠ last_owner wins. Winner's fields are latched, owner is set, next state is REQ.
- REQ: mem_req_o=1, fields constant. On mem_gnt_i, go to WAIT and set last_owner=owner.
- WAIT: mem_req_o=0. On mem_rvalid_i, pulse owner's valid_o next cycle and go to IDLE. For a load, capture mem_rdata_i into owner's rdata_o. A store leaves d_rdata_o unchanged.
- Fetch requests always have mem_we_o=0 and mem_be_o all ones.
- A mem_rvalid_i in IDLE/REQ, or in the gnt cycle, is ignored and sets proto_err_o.
- Requester inputs are sampled only in IDLE. Changes while stalled are a requester protocol violation and are not checked.

## Timing
- Reset (async): state=IDLE, last_owner=IF so data wins the first tie; proto_err_o cleared. All outputs 0: mem_*, valid_o, rdata_o, proto_err_o.
- Minimum latency: req_i at cycle N, mem_req_o at N+1. With gnt at N+1, WAIT at N+2. With rvalid at N+2, valid_o at N+3. That gives 3 cycles for request-to-response.
- Back-to-back: same requester re-arbitrated earliest in the cycle after its valid_o. Competing requester can win in the valid_o cycle.
- Wait states on gnt/rvalid extend REQ/WAIT indefinitely; there is no timeout.
- rst_i mid-transaction aborts it. No valid_o is issued, and a late rvalid sets proto_err_o.
- rdata_o holds its value until the owner's next load response.

## Structure
- Shared package/header mem_arb_pkg: state encodings (IDLE=2'd0, REQ=2'd1, WAIT=2'd2), owner encodings (OWN_IF=1'b0, OWN_D=1'b1).
- One sub-module: arb_pick2, combinational 2-way pick from (req_if, req_d, last_owner) → grant_d, valid. Remainder in mem_port_arbiter.

## Test plan
- Lone fetch: if_req_i, addr 0x100, gnt immediately, rvalid 1 cycle later with 0x00500093 → if_valid_o at N+3, if_rdata_o=0x00500093, if_stall_o high N..N+2.
- Simultaneous fetch and load after reset: data granted first (mem_addr_o=d_addr_i). Fetch goes next, without an intervening IDLE-cycle loss. Then alternation repeats when both are held continuously.
- Store with d_be_i=4'b0011, 3-cycle gnt delay and 2-cycle rvalid delay: mem fields stable through REQ. d_valid_o fires once and d_rdata_o is unchanged.
- Held requests: both req held for 6 transactions → grants IF,D alternate strictly. No requester is granted twice in a row while the other waits.
- rst_i asserted in WAIT, then rvalid arrives after release → no valid_o, all outputs 0 during reset, proto_err_o=1 afterward.
- mem_rvalid_i pulsed in IDLE → ignored, proto_err_o sticks at 1 until reset.
